pos_eval_seq: RTL and testbench

- Programmable, pipelined product-of-sums logic evaluator.
- Each of N_TERMS OR-terms selects any subset of the N_IN inputs, with optional per-input inversion; the output is the AND of all terms.
- The function is loaded at run time over a serial config port with atomic commit. Results are registered, counted and edge-flagged.
- Replaces hard-wired single-function gate tiles: any PoS function up to N_TERMS clauses is one instance.

---
 rtl/pos_eval_seq.sv | 134 +++++++++++++
 tb/tb_pos_eval_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_eval_seq.sv
// Run-time programmable product-of-sums evaluator. A serial config port loads a
// shadow word that commits atomically, and a two-stage pipeline evaluates vectors.
module pos_eval_seq #(
    parameter int N_IN    = 8,
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    output logic             cfg_done,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    output logic             out_result,
    output logic             out_rise,
    output logic [CNT_W-1:0] hit_count,
    input  logic             cnt_clr
);
    localparam int CFG_BITS = N_TERMS * 2 * N_IN;
    localparam int BCNT_W   = $clog2(CFG_BITS);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(CFG_BITS - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic [CFG_BITS-1:0] w_shifted;
    logic [BCNT_W-1:0]   r_bitCnt;
    logic                w_accept;
    logic                w_lastBit;
    logic [N_TERMS-1:0]  w_terms;
    logic [N_TERMS-1:0]  r_terms;
    logic [N_IN-1:0]     w_mask;
    logic [N_IN-1:0]     w_inv;
    logic                r_v1;
    logic                r_prev;
    logic                w_and;
    logic                w_hit;

    // A restart pulse wins over a bit offered in the same cycle.
    assign w_accept  = (r_state == LOAD) && cfg_valid && !cfg_start;
    assign w_lastBit = w_accept && (r_bitCnt == LAST_BIT);
    assign w_shifted = {r_shadow[CFG_BITS-2:0], cfg_bit};
    assign cfg_busy  = (r_state == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (cfg_start) w_nextState = LOAD;
            LOAD:    if (w_lastBit) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_bitCnt <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (cfg_start) begin
                r_shadow <= '0;
                r_bitCnt <= '0;
            end else if (w_accept) begin
                r_shadow <= w_shifted;
                if (w_lastBit) begin
                    r_active <= w_shifted;
                    r_bitCnt <= '0;
                    cfg_done <= 1'b1;
                end else begin
                    r_bitCnt <= r_bitCnt + BCNT_W'(1);
                end
            end
        end
    end

    // An empty mask is a don't-care clause and must not veto the AND.
    always_comb begin
        w_terms = '0;
        w_mask  = '0;
        w_inv   = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            w_mask     = r_active[t*2*N_IN +: N_IN];
            w_inv      = r_active[t*2*N_IN + N_IN +: N_IN];
            w_terms[t] = (w_mask == '0) || (|(w_mask & (in_data ^ w_inv)));
        end
    end

    assign w_and = &r_terms;
    assign w_hit = r_v1 && w_and;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_terms    <= '0;
            out_valid  <= 1'b0;
            out_result <= 1'b0;
            out_rise   <= 1'b0;
            r_prev     <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) r_terms <= w_terms;
            out_valid  <= r_v1;
            out_result <= w_hit;
            out_rise   <= w_hit && !r_prev;
            if (r_v1) r_prev <= w_and;
        end
    end

    // The counter moves on the same edge that presents the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (cnt_clr) begin
            hit_count <= '0;
        end else if (w_hit && (hit_count != '1)) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pos_eval_seq.sv
// Directed bench for pos_eval_seq: table-driven vectors under several loaded
// configs, plus hand-written sequences for abort, saturation, clear and reset.
module tb_pos_eval_seq;
    localparam int N_IN    = 8;
    localparam int N_TERMS = 4;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_start;
    logic             cfg_valid;
    logic             cfg_bit;
    logic             cfg_busy;
    logic             cfg_done;
    logic             in_valid;
    logic [N_IN-1:0]  in_data;
    logic             out_valid;
    logic             out_result;
    logic             out_rise;
    logic [CNT_W-1:0] hit_count;
    logic             cnt_clr;

    always #5 clk = ~clk;

    pos_eval_seq #(.N_IN(N_IN), .N_TERMS(N_TERMS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_result(out_result), .out_rise(out_rise),
        .hit_count(hit_count), .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic [7:0] data;
        logic       expResult;
        logic       expRise;
    } vec_t;

    vec_t vecs[13];
    int   passCount  = 0;
    int   checkCount = 0;
    int   modelCount = 0;
    int   doneSeen;
    bit   busyOk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Compares a presented result; the hit counter is tracked by a saturating model.
    task automatic checkResult(input string tag, input logic expResult, input logic expRise);
        if (expResult && modelCount < (2**CNT_W - 1)) modelCount++;
        checkOutput({tag, " valid"},  32'(out_valid),  32'd1);
        checkOutput({tag, " result"}, 32'(out_result), 32'(expResult));
        checkOutput({tag, " rise"},   32'(out_rise),   32'(expRise));
        checkOutput({tag, " hits"},   32'(hit_count),  32'(modelCount));
    endtask

    // Single vector in, then wait the two pipeline stages.
    task automatic applyStimulus(input logic [7:0] data);
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic runTable(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i].data);
            checkResult($sformatf("vec%0d", i), vecs[i].expResult, vecs[i].expRise);
        end
    endtask

    // Back-to-back issue; result k appears two edges after vector k enters.
    task automatic runStream(input int first, input int last);
        for (int k = first; k <= last + 1; k++) begin
            if (k <= last) begin
                in_valid = 1'b1;
                in_data  = vecs[k].data;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k > first)
                checkResult($sformatf("stream%0d", k - 1), vecs[k-1].expResult, vecs[k-1].expRise);
        end
        in_valid = 1'b0;
        tick();
    endtask

    // Shifts nBits of word MSB first with five scattered stall cycles.
    task automatic loadConfig(input logic [63:0] word, input int nBits, input logic startWithBit,
                              output int doneCnt, output bit busyGood);
        doneCnt   = 0;
        busyGood  = 1'b1;
        cfg_start = 1'b1;
        cfg_valid = startWithBit;
        cfg_bit   = startWithBit;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        if (!cfg_busy) busyGood = 1'b0;
        for (int i = 0; i < nBits; i++) begin
            if (i % 13 == 7) begin
                tick();
                if (!cfg_busy) busyGood = 1'b0;
                if (cfg_done) doneCnt++;
            end
            cfg_valid = 1'b1;
            cfg_bit   = word[63 - i];
            tick();
            cfg_valid = 1'b0;
            if (cfg_done) doneCnt++;
            if (i < 63 && !cfg_busy) busyGood = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{8'h00, 1'b1, 1'b1};
        vecs[1]  = '{8'h91, 1'b1, 1'b0};
        vecs[2]  = '{8'h11, 1'b0, 1'b0};
        vecs[3]  = '{8'h88, 1'b0, 1'b0};
        vecs[4]  = '{8'h11, 1'b1, 1'b1};
        vecs[5]  = '{8'h91, 1'b0, 1'b0};
        vecs[6]  = '{8'h88, 1'b0, 1'b0};
        vecs[7]  = '{8'h99, 1'b0, 1'b0};
        vecs[8]  = '{8'h02, 1'b1, 1'b0};
        vecs[9]  = '{8'h11, 1'b0, 1'b0};
        vecs[10] = '{8'h03, 1'b0, 1'b0};
        vecs[11] = '{8'h00, 1'b0, 1'b0};
        vecs[12] = '{8'h06, 1'b1, 1'b1};

        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid",  32'(out_valid),  32'd0);
        checkOutput("reset out_result", 32'(out_result), 32'd0);
        checkOutput("reset out_rise",   32'(out_rise),   32'd0);
        checkOutput("reset hit_count",  32'(hit_count),  32'd0);
        checkOutput("reset cfg_busy",   32'(cfg_busy),   32'd0);
        checkOutput("reset cfg_done",   32'(cfg_done),   32'd0);
        rst = 1'b0;
        tick();

        // All-zero config makes every vector true.
        runTable(0, 0);

        // t0 mask 09, t1 mask 50, t2 mask 80, t3 empty.
        loadConfig(64'h0000_0080_0050_0009, 64, 1'b0, doneSeen, busyOk);
        checkOutput("cfg1 busy held",   32'(busyOk),   32'd1);
        checkOutput("cfg1 done pulses", 32'(doneSeen), 32'd1);
        checkOutput("cfg1 busy drop",   32'(cfg_busy), 32'd0);
        tick();
        checkOutput("cfg1 done width",  32'(cfg_done), 32'd0);
        runTable(1, 3);

        // Same clauses with t2 inverted, streamed back-to-back.
        loadConfig(64'h0000_8080_0050_0009, 64, 1'b0, doneSeen, busyOk);
        checkOutput("cfg2 busy held",   32'(busyOk),   32'd1);
        checkOutput("cfg2 done pulses", 32'(doneSeen), 32'd1);
        tick();
        runStream(4, 7);

        // Partial load, a vector during it, then a restart that offers a bit.
        loadConfig(64'hFFFF_FFFF_FFFF_FFFF, 30, 1'b0, doneSeen, busyOk);
        checkOutput("abort busy held", 32'(busyOk),   32'd1);
        checkOutput("abort no done",   32'(doneSeen), 32'd0);
        applyStimulus(8'h11);
        checkResult("mid-load vec", 1'b1, 1'b1);
        checkOutput("mid-load busy", 32'(cfg_busy), 32'd1);
        loadConfig(64'h0000_0000_0002_0101, 64, 1'b1, doneSeen, busyOk);
        checkOutput("cfg4 busy held",   32'(busyOk),   32'd1);
        checkOutput("cfg4 done pulses", 32'(doneSeen), 32'd1);
        checkOutput("cfg4 busy drop",   32'(cfg_busy), 32'd0);

        // Serial bits while idle must not disturb anything.
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        repeat (3) tick();
        cfg_valid = 1'b0;
        checkOutput("idle valid busy", 32'(cfg_busy), 32'd0);
        checkOutput("idle valid done", 32'(cfg_done), 32'd0);
        runTable(8, 12);

        // Twenty consecutive hits drive the counter into saturation.
        in_valid = 1'b1;
        in_data  = 8'h02;
        repeat (20) tick();
        in_valid = 1'b0;
        repeat (2) tick();
        checkOutput("saturated hits", 32'(hit_count), 32'd15);
        modelCount = 15;

        // Clear lands on the same edge as a hit.
        in_valid = 1'b1;
        in_data  = 8'h02;
        tick();
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        checkOutput("clr out_valid",  32'(out_valid),  32'd1);
        checkOutput("clr out_result", 32'(out_result), 32'd1);
        checkOutput("clr hit_count",  32'(hit_count),  32'd0);
        modelCount = 0;
        applyStimulus(8'h02);
        checkResult("post-clr", 1'b1, 1'b0);

        // Reset mid-load with a true vector in flight.
        loadConfig(64'h0, 20, 1'b0, doneSeen, busyOk);
        in_valid = 1'b1;
        in_data  = 8'h02;
        tick();
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        checkOutput("async rst hits", 32'(hit_count), 32'd0);
        checkOutput("async rst busy", 32'(cfg_busy),  32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst inflight valid",  32'(out_valid),  32'd0);
        checkOutput("rst inflight result", 32'(out_result), 32'd0);
        rst = 1'b0;
        tick();
        modelCount = 0;
        applyStimulus(8'h11);
        checkResult("post-rst", 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
